// File: rtl/nios2_dbg_sysclk_cmd_mux_pkg.sv
// Shared action codes, IR codes and the IR/shift-register decode
// for the Nios II debug system-clock command mux.
package nios2_dbg_pkg;

  typedef enum logic [3:0] {
    ACT_NONE           = 4'd0,
    ACT_OCIMEM_A       = 4'd1,
    ACT_OCIMEM_B       = 4'd2,
    ACT_NOACT_OCIMEM_A = 4'd3,
    ACT_BREAK_A        = 4'd4,
    ACT_BREAK_B        = 4'd5,
    ACT_BREAK_C        = 4'd6,
    ACT_NOACT_BREAK_A  = 4'd7,
    ACT_NOACT_BREAK_B  = 4'd8,
    ACT_NOACT_BREAK_C  = 4'd9,
    ACT_TRACECTRL      = 4'd10
  } act_e;

  localparam int unsigned IR_OCIMEM    = 0;
  localparam int unsigned IR_TRACEMEM  = 1;
  localparam int unsigned IR_BREAK     = 2;
  localparam int unsigned IR_TRACECTRL = 3;

  // top = {SEL[1:0], EN, B34}, i.e. the four most significant shift-register bits.
  function automatic act_e decode_act(input int unsigned ir, input logic [3:0] top);
    act_e       code;
    logic [1:0] sel;
    logic       en;
    logic       b34;
    sel  = top[3:2];
    en   = top[1];
    b34  = top[0];
    code = ACT_NONE;
    case (ir)
      IR_OCIMEM: begin
        if (en) code = b34 ? ACT_OCIMEM_A : ACT_OCIMEM_B;
        else    code = ACT_NOACT_OCIMEM_A;
      end
      IR_BREAK: begin
        if (sel != 2'b11) begin
          if (en) code = act_e'(4'(ACT_BREAK_A) + {2'b00, sel});
          else    code = act_e'(4'(ACT_NOACT_BREAK_A) + {2'b00, sel});
        end
      end
      IR_TRACECTRL: begin
        if (en) code = ACT_TRACECTRL;
      end
      default: code = ACT_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/nios2_dbg_sysclk_cmd_mux_if.sv
// TCK-side inputs, captured data and per-channel action handshake of the
// debug command mux, bundled for connection between JTAG logic and OCI blocks.
interface nios2_dbg_sysclk_cmd_mux_if #(
  parameter int unsigned SR_W = 38,
  parameter int unsigned IR_W = 2,
  parameter int unsigned N_CH = 1,
  parameter int unsigned CH_W = 3
);
  logic              udr_tog;
  logic              uir_tog;
  logic [SR_W-1:0]   sr;
  logic [IR_W-1:0]   ir_in;
  logic [CH_W-1:0]   ch_sel;
  logic [SR_W-1:0]   jdo;
  logic [IR_W-1:0]   ir_q;
  logic [CH_W-1:0]   ch_q;
  logic [N_CH-1:0]   act_valid;
  logic [4*N_CH-1:0] act_code;
  logic [N_CH-1:0]   act_ready;
  logic [N_CH-1:0]   overrun;

  modport master (
    output udr_tog, uir_tog, sr, ir_in, ch_sel, act_ready,
    input  jdo, ir_q, ch_q, act_valid, act_code, overrun
  );

  modport slave (
    input  udr_tog, uir_tog, sr, ir_in, ch_sel, act_ready,
    output jdo, ir_q, ch_q, act_valid, act_code, overrun
  );
endinterface

// File: rtl/nios2_dbg_sysclk_cmd_mux_toggle_sync.sv
// Synchronises a TCK-domain toggle into clk and emits a one-cycle event per flip,
// suppressed while the chain primes after reset.
module nios2_dbg_toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tog,
  output logic evt
);

  localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic [2:0]             prime_q;

  // The delayed copy keeps tracking during prime so a level held through
  // reset release is absorbed instead of reported as a flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      prime_q <= '0;
      evt     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog};
      dly_q  <= sync_q[SYNC_STAGES-1];
      if (prime_q != PRIME_N) begin
        prime_q <= prime_q + 3'd1;
        evt     <= 1'b0;
      end else begin
        evt <= sync_q[SYNC_STAGES-1] ^ dly_q;
      end
    end
  end

endmodule

// File: rtl/nios2_dbg_sysclk_cmd_mux.sv
// System-clock side of the Nios II debug slave: captures jdo on update-DR and
// routes decoded actions to N_CH channels under valid/ready with overrun flags.
module nios2_dbg_sysclk_cmd_mux
  import nios2_dbg_pkg::*;
#(
  parameter int unsigned SR_W        = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned N_CH        = 1,
  parameter int unsigned CH_W        = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                      clk,
  input logic                      reset,
  nios2_dbg_sysclk_cmd_mux_if.slave bus
);

  logic uir_evt;
  logic udr_evt;

  logic [SR_W-1:0]   jdo_q,   jdo_n;
  logic [IR_W-1:0]   ir_q,    ir_n;
  logic [CH_W-1:0]   ch_q,    ch_n;
  logic [N_CH-1:0]   valid_q, valid_n;
  logic [4*N_CH-1:0] code_q,  code_n;
  logic [N_CH-1:0]   ovr_q,   ovr_n;
  act_e              dec;

  nios2_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk   (clk),
    .reset (reset),
    .tog   (bus.uir_tog),
    .evt   (uir_evt)
  );

  nios2_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk   (clk),
    .reset (reset),
    .tog   (bus.udr_tog),
    .evt   (udr_evt)
  );

  assign dec = decode_act(32'(ir_q), bus.sr[SR_W-1 -: 4]);

  // Overrun clear from uir is applied before the udr set so a same-cycle
  // collision on one channel resolves as set.
  always_comb begin
    jdo_n   = jdo_q;
    ir_n    = ir_q;
    ch_n    = ch_q;
    valid_n = valid_q & ~bus.act_ready;
    code_n  = code_q;
    ovr_n   = ovr_q;
    if (uir_evt) begin
      ir_n = bus.ir_in;
      ch_n = bus.ch_sel;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (32'(bus.ch_sel) == i) ovr_n[i] = 1'b0;
      end
    end
    if (udr_evt) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (32'(ch_q) == i) begin
          if (valid_q[i] && !bus.act_ready[i] && (dec != ACT_NONE)) begin
            ovr_n[i] = 1'b1;
          end else begin
            jdo_n = bus.sr;
            if (dec != ACT_NONE) begin
              code_n[4*i +: 4] = dec;
              valid_n[i]       = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_q   <= '0;
      ir_q    <= '0;
      ch_q    <= '0;
      valid_q <= '0;
      code_q  <= '0;
      ovr_q   <= '0;
    end else begin
      jdo_q   <= jdo_n;
      ir_q    <= ir_n;
      ch_q    <= ch_n;
      valid_q <= valid_n;
      code_q  <= code_n;
      ovr_q   <= ovr_n;
    end
  end

  assign bus.jdo       = jdo_q;
  assign bus.ir_q      = ir_q;
  assign bus.ch_q      = ch_q;
  assign bus.act_valid = valid_q;
  assign bus.act_code  = code_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_nios2_dbg_sysclk_cmd_mux.sv
// Directed bench for the debug command mux with four channels.
module tb_nios2_dbg_sysclk_cmd_mux;

  localparam int unsigned SR_W = 38;
  localparam int unsigned IR_W = 2;
  localparam int unsigned N_CH = 4;
  localparam int unsigned CH_W = 3;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  nios2_dbg_sysclk_cmd_mux_if #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH), .CH_W(CH_W)) bus ();

  nios2_dbg_sysclk_cmd_mux #(
    .SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH), .CH_W(CH_W), .SYNC_STAGES(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [SR_W-1:0] mk_sr(input logic [1:0] sel, input logic en,
                                            input logic b34, input logic [33:0] low);
    return {sel, en, b34, low};
  endfunction

  task automatic do_uir(input logic [IR_W-1:0] ir, input logic [CH_W-1:0] ch);
    bus.ir_in   = ir;
    bus.ch_sel  = ch;
    bus.uir_tog = ~bus.uir_tog;
    ticks(4);
  endtask

  task automatic do_udr(input logic [SR_W-1:0] v);
    bus.sr      = v;
    bus.udr_tog = ~bus.udr_tog;
    ticks(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(2);
    total_cnt++;
    if (bus.jdo !== '0 || bus.ir_q !== '0 || bus.ch_q !== '0 || bus.act_valid !== '0 ||
        bus.act_code !== '0 || bus.overrun !== '0)
      $display("FAIL reset_state: jdo=%h ir_q=%h ch_q=%h valid=%b code=%h ovr=%b, need all 0",
               bus.jdo, bus.ir_q, bus.ch_q, bus.act_valid, bus.act_code, bus.overrun);
    else pass_cnt++;
    reset = 1'b0;
    ticks(6);
  endtask

  task automatic test_basic();
    logic [SR_W-1:0] v;
    do_uir(2'd0, 3'd0);
    total_cnt++;
    if (bus.ir_q !== 2'd0 || bus.ch_q !== 3'd0)
      $display("FAIL basic_uir: ir_q=%0d ch_q=%0d, need 0/0", bus.ir_q, bus.ch_q);
    else pass_cnt++;
    v = mk_sr(2'b00, 1'b1, 1'b1, 34'h0_0000_A5C3);
    bus.sr      = v;
    bus.udr_tog = ~bus.udr_tog;
    ticks(3);
    total_cnt++;
    if (bus.act_valid !== 4'b0000 || bus.jdo !== '0)
      $display("FAIL basic_early: valid=%b jdo=%h at k+2, need 0000/0", bus.act_valid, bus.jdo);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.act_valid !== 4'b0001 || bus.act_code[3:0] !== 4'd1 || bus.jdo !== v)
      $display("FAIL basic_commit: valid=%b code=%0d jdo=%h, need 0001/1/%h",
               bus.act_valid, bus.act_code[3:0], bus.jdo, v);
    else pass_cnt++;
    bus.act_ready = 4'b0001;
    tick();
    bus.act_ready = 4'b0000;
    total_cnt++;
    if (bus.act_valid !== 4'b0000 || bus.act_code[3:0] !== 4'd1)
      $display("FAIL basic_ready: valid=%b code=%0d, need 0000/1", bus.act_valid, bus.act_code[3:0]);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [SR_W-1:0] v1;
    v1 = mk_sr(2'b01, 1'b1, 1'b0, 34'h1_2345_6789);
    do_uir(2'd2, 3'd2);
    do_udr(v1);
    total_cnt++;
    if (bus.act_valid !== 4'b0100 || bus.act_code[11:8] !== 4'd5 || bus.jdo !== v1)
      $display("FAIL ovr_first: valid=%b code=%0d jdo=%h, need 0100/5/%h",
               bus.act_valid, bus.act_code[11:8], bus.jdo, v1);
    else pass_cnt++;
    do_udr(mk_sr(2'b00, 1'b1, 1'b0, 34'h0_0000_0BAD));
    total_cnt++;
    if (bus.overrun !== 4'b0100 || bus.jdo !== v1 || bus.act_code[11:8] !== 4'd5 ||
        bus.act_valid !== 4'b0100)
      $display("FAIL ovr_set: ovr=%b jdo=%h code=%0d valid=%b, need 0100/%h/5/0100",
               bus.overrun, bus.jdo, bus.act_code[11:8], bus.act_valid, v1);
    else pass_cnt++;
    do_uir(2'd2, 3'd2);
    total_cnt++;
    if (bus.overrun !== 4'b0000)
      $display("FAIL ovr_clear: ovr=%b, need 0000", bus.overrun);
    else pass_cnt++;
    bus.act_ready = 4'b0100;
    tick();
    bus.act_ready = 4'b0000;
    total_cnt++;
    if (bus.act_valid !== 4'b0000)
      $display("FAIL ovr_consume: valid=%b, need 0000", bus.act_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [SR_W-1:0] v2;
    v2 = mk_sr(2'b00, 1'b1, 1'b0, 34'h0_0000_0022);
    do_uir(2'd0, 3'd0);
    do_udr(mk_sr(2'b00, 1'b1, 1'b1, 34'h0_0000_0011));
    bus.sr      = v2;
    bus.udr_tog = ~bus.udr_tog;
    ticks(3);
    bus.act_ready = 4'b0001;
    tick();
    bus.act_ready = 4'b0000;
    total_cnt++;
    if (bus.act_valid !== 4'b0001 || bus.act_code[3:0] !== 4'd2 || bus.overrun !== 4'b0000 ||
        bus.jdo !== v2)
      $display("FAIL b2b_collide: valid=%b code=%0d ovr=%b jdo=%h, need 0001/2/0000/%h",
               bus.act_valid, bus.act_code[3:0], bus.overrun, bus.jdo, v2);
    else pass_cnt++;
    bus.act_ready = 4'b0001;
    tick();
    tick();
    bus.act_ready = 4'b0000;
    total_cnt++;
    if (bus.act_valid !== 4'b0000 || bus.act_code[3:0] !== 4'd2)
      $display("FAIL b2b_idle_ready: valid=%b code=%0d, need 0000/2", bus.act_valid, bus.act_code[3:0]);
    else pass_cnt++;
  endtask

  task automatic test_drop();
    logic [SR_W-1:0] prev;
    logic [SR_W-1:0] v;
    prev = bus.jdo;
    do_uir(2'd2, 3'd5);
    total_cnt++;
    if (bus.ch_q !== 3'd5 || bus.ir_q !== 2'd2)
      $display("FAIL drop_uir: ch_q=%0d ir_q=%0d, need 5/2", bus.ch_q, bus.ir_q);
    else pass_cnt++;
    do_udr(mk_sr(2'b00, 1'b1, 1'b0, 34'h0_0000_0033));
    total_cnt++;
    if (bus.act_valid !== 4'b0000 || bus.overrun !== 4'b0000 || bus.jdo !== prev)
      $display("FAIL drop_oob: valid=%b ovr=%b jdo=%h, need 0000/0000/%h",
               bus.act_valid, bus.overrun, bus.jdo, prev);
    else pass_cnt++;
    v = mk_sr(2'b11, 1'b1, 1'b1, 34'h0_0000_0044);
    do_uir(2'd1, 3'd1);
    do_udr(v);
    total_cnt++;
    if (bus.act_valid !== 4'b0000 || bus.jdo !== v)
      $display("FAIL drop_ir1: valid=%b jdo=%h, need 0000/%h", bus.act_valid, bus.jdo, v);
    else pass_cnt++;
  endtask

  task automatic test_prime_simul();
    logic [SR_W-1:0] v;
    reset       = 1'b1;
    bus.uir_tog = 1'b1;
    bus.ir_in   = 2'd3;
    bus.ch_sel  = 3'd1;
    ticks(2);
    reset = 1'b0;
    ticks(8);
    total_cnt++;
    if (bus.ir_q !== 2'd0 || bus.ch_q !== 3'd0 || bus.act_valid !== 4'b0000)
      $display("FAIL prime_quiet: ir_q=%0d ch_q=%0d valid=%b, need 0/0/0000",
               bus.ir_q, bus.ch_q, bus.act_valid);
    else pass_cnt++;
    v = mk_sr(2'b00, 1'b1, 1'b1, 34'h0_0000_0055);
    bus.sr      = v;
    bus.udr_tog = ~bus.udr_tog;
    bus.uir_tog = ~bus.uir_tog;
    ticks(4);
    total_cnt++;
    if (bus.ir_q !== 2'd3 || bus.ch_q !== 3'd1)
      $display("FAIL simul_uir: ir_q=%0d ch_q=%0d, need 3/1", bus.ir_q, bus.ch_q);
    else pass_cnt++;
    total_cnt++;
    if (bus.act_valid !== 4'b0001 || bus.act_code[3:0] !== 4'd1 || bus.jdo !== v)
      $display("FAIL simul_old_ir: valid=%b code=%0d jdo=%h, need 0001/1/%h",
               bus.act_valid, bus.act_code[3:0], bus.jdo, v);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset       = 1'b1;
    bus.udr_tog = ~bus.udr_tog;
    #1;
    total_cnt++;
    if (bus.jdo !== '0 || bus.ir_q !== '0 || bus.ch_q !== '0 || bus.act_valid !== '0 ||
        bus.act_code !== '0 || bus.overrun !== '0)
      $display("FAIL async_reset: jdo=%h ir_q=%h ch_q=%h valid=%b code=%h ovr=%b, need all 0",
               bus.jdo, bus.ir_q, bus.ch_q, bus.act_valid, bus.act_code, bus.overrun);
    else pass_cnt++;
    ticks(2);
    reset = 1'b0;
    ticks(8);
    total_cnt++;
    if (bus.act_valid !== 4'b0000 || bus.ir_q !== 2'd0 || bus.jdo !== '0)
      $display("FAIL post_reset_quiet: valid=%b ir_q=%0d jdo=%h, need 0000/0/0",
               bus.act_valid, bus.ir_q, bus.jdo);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    reset         = 1'b1;
    bus.udr_tog   = 1'b0;
    bus.uir_tog   = 1'b0;
    bus.sr        = '0;
    bus.ir_in     = '0;
    bus.ch_sel    = '0;
    bus.act_ready = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_drop();
    test_prime_simul();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
